contador_bcd: RTL and testbench

- Multi-digit, prescaled BCD up/down counter.
- Produces one packed 4-bit BCD nibble per digit; each nibble drives the `entrada` of one bcd_7segments decoder instance.
- Sits directly upstream of the display decoders: counter value → per-digit decoders → 7-segment displays.
- Provides synchronous load, pause/enable, count direction and a one-cycle wrap flag for cascading or alarms.

---
 rtl/contador_bcd.sv | 173 +++++++++++++++++
 tb/tb_contador_bcd.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/contador_bcd.sv
// contador_bcd: multi-digit prescaled BCD up/down counter.
// Each 4-bit nibble of `digitos` feeds one 7-segment decoder. A prescaler
// divides clk down to a count-step tick. A synchronous load sanitises
// invalid nibbles to 0, and `estouro` pulses for one cycle on every wrap.
module contador_bcd #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  habilita,
    input  logic                  direcao,
    input  logic                  carrega,
    input  logic [4*DIGITS-1:0]   valor_carga,
    output logic [4*DIGITS-1:0]   digitos,
    output logic                  estouro
);

    // Prescaler width: at least one bit, even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    // ------------------------------------------------------------------
    // BCD helper functions
    // ------------------------------------------------------------------

    // A nibble above 9 is not a decimal digit. Replace it with 0 so that
    // no invalid code can ever reach a display decoder.
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
        logic [3:0] res;
        if (nib > 4'd9) begin
            res = 4'd0;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Increment one BCD digit: 9 wraps to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd9) begin
            res = 4'd0;
        end else begin
            res = nib + 4'd1;
        end
        return res;
    endfunction

    // Decrement one BCD digit: 0 wraps to 9. Any illegal code is treated
    // as 0, so the result always lands in 0..9.
    function automatic logic [3:0] bcd_dec(input logic [3:0] nib);
        logic [3:0] res;
        if (nib == 4'd0 || nib > 4'd9) begin
            res = 4'd9;
        end else begin
            res = nib - 4'd1;
        end
        return res;
    endfunction

    // Report whether this digit passes a carry or borrow to the next digit.
    function automatic logic bcd_ripples(input logic [3:0] nib, input logic up);
        logic res;
        if (up) begin
            res = (nib >= 4'd9);
        end else begin
            res = (nib == 4'd0) || (nib > 4'd9);
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]         pre_cnt_r;
    logic [4*DIGITS-1:0]   digitos_r;
    logic                  estouro_r;

    logic                  tick_s;
    logic [4*DIGITS-1:0]   step_val_s;
    logic                  wrap_s;
    logic [4*DIGITS-1:0]   load_val_s;

    // The tick exists only while counting is enabled and the prescaler
    // has reached the end of its period.
    always_comb begin
        tick_s = 1'b0;
        if (habilita && (pre_cnt_r == PRE_MAX)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Ripple the carry or borrow from digit 0 upwards. A carry that leaves
    // the top digit means the whole counter wrapped.
    always_comb begin
        logic cy;
        step_val_s = digitos_r;
        wrap_s     = 1'b0;
        cy         = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (direcao) begin
                    step_val_s[4*i +: 4] = bcd_inc(digitos_r[4*i +: 4]);
                end else begin
                    step_val_s[4*i +: 4] = bcd_dec(digitos_r[4*i +: 4]);
                end
                cy = bcd_ripples(digitos_r[4*i +: 4], direcao);
            end else begin
                step_val_s[4*i +: 4] = digitos_r[4*i +: 4];
            end
        end
        wrap_s = cy;
    end

    // Sanitise each incoming load nibble independently of the others.
    always_comb begin
        load_val_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_val_s[4*i +: 4] = bcd_sanitize(valor_carga[4*i +: 4]);
        end
    end

    // Prescaler. A load restarts a full period, and a pause holds the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_r <= '0;
        end else if (carrega) begin
            pre_cnt_r <= '0;
        end else if (habilita) begin
            if (pre_cnt_r == PRE_MAX) begin
                pre_cnt_r <= '0;
            end else begin
                pre_cnt_r <= pre_cnt_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            pre_cnt_r <= pre_cnt_r;
        end
    end

    // Digit register. Priority is reset, then load, then the count step.
    always_ff @(posedge clk) begin
        if (reset) begin
            digitos_r <= '0;
        end else if (carrega) begin
            digitos_r <= load_val_s;
        end else if (tick_s) begin
            digitos_r <= step_val_s;
        end else begin
            digitos_r <= digitos_r;
        end
    end

    // Wrap flag. It is registered alongside the digits, so it is high in
    // the same cycle that the wrapped value first appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            estouro_r <= 1'b0;
        end else if (carrega) begin
            estouro_r <= 1'b0;
        end else if (tick_s) begin
            estouro_r <= wrap_s;
        end else begin
            estouro_r <= 1'b0;
        end
    end

    assign digitos = digitos_r;
    assign estouro = estouro_r;

endmodule

// File: tb/tb_contador_bcd.sv
// Testbench for contador_bcd (DIGITS=4, PRESCALE=4). It runs a table of
// directed vectors with hand-computed expectations, plus hand-written
// sequences for reset, the first tick after reset, and reset mid-count.
module tb_contador_bcd;

    logic        clk;
    logic        reset;
    logic        habilita;
    logic        direcao;
    logic        carrega;
    logic [15:0] valor_carga;
    logic [15:0] digitos;
    logic        estouro;

    int checks;
    int errors;

    contador_bcd #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .habilita    (habilita),
        .direcao     (direcao),
        .carrega     (carrega),
        .valor_carga (valor_carga),
        .digitos     (digitos),
        .estouro     (estouro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hab;
        logic        dir;
        logic        ld;
        logic [15:0] val;
        int          ncyc;
        logic [15:0] exp_dig;
        logic        exp_est;
    } vec_t;

    vec_t vecs[27];

    // Advance n rising edges, then wait 1 time unit so that outputs are
    // sampled away from the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] exp_dig, input logic exp_est);
        checks++;
        if (digitos !== exp_dig || estouro !== exp_est) begin
            errors++;
            $display("FAIL %s: digitos=%h estouro=%b, expected digitos=%h estouro=%b",
                     name, digitos, estouro, exp_dig, exp_est);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            if (digitos[4*i +: 4] > 4'd9) begin
                errors++;
                $display("FAIL %s_bcd: nibble %0d = %h, expected 0..9", name, i, digitos[4*i +: 4]);
                break;
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        habilita    = 1'b0;
        direcao     = 1'b1;
        carrega     = 1'b0;
        valor_carga = 16'h0000;

        // Fields: hab, dir, ld, val, ncyc, exp_dig, exp_est.
        // Each vector starts with the prescaler at the value noted.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0099, 1,  16'h0099, 1'b0}; // load, pre -> 0
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 3,  16'h0099, 1'b0}; // pre 0 -> 3
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1,  16'h0100, 1'b0}; // tick: 0099 -> 0100
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1,  16'h0100, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h9999, 1,  16'h9999, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 3,  16'h9999, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1,  16'h0000, 1'b1}; // up wrap
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1,  16'h0000, 1'b0}; // pulse gone
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1,  16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4,  16'h9999, 1'b1}; // down wrap
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1,  16'h9999, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 3,  16'h9998, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h1A3F, 1,  16'h1030, 1'b0}; // sanitise
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 20, 16'h1030, 1'b0}; // paused
        vecs[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 3,  16'h1030, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1,  16'h1031, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16'h0000, 3,  16'h1031, 1'b0}; // pre = 3
        vecs[17] = '{1'b1, 1'b1, 1'b1, 16'h0042, 1,  16'h0042, 1'b0}; // load wins on tick
        vecs[18] = '{1'b1, 1'b1, 1'b0, 16'h0000, 3,  16'h0042, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1,  16'h0043, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 16'h0100, 1,  16'h0100, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4,  16'h0099, 1'b0}; // borrow chain
        vecs[22] = '{1'b1, 1'b1, 1'b1, 16'h9999, 1,  16'h9999, 1'b0};
        vecs[23] = '{1'b1, 1'b1, 1'b0, 16'h0000, 3,  16'h9999, 1'b0}; // pre = 3
        vecs[24] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1,  16'h0000, 1'b0}; // load masks wrap
        vecs[25] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2,  16'h0000, 1'b0}; // dir=0 between ticks
        vecs[26] = '{1'b1, 1'b1, 1'b0, 16'h0000, 2,  16'h0001, 1'b0}; // dir=1 at tick

        // Reset state.
        step(2);
        check("reset_state", 16'h0000, 1'b0);

        // The first step lands on the 4th enabled edge after reset.
        reset    = 1'b0;
        habilita = 1'b1;
        direcao  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check("first_period", 16'h0000, 1'b0);
        end
        step(1);
        check("first_tick", 16'h0001, 1'b0);
        step(3);
        check("second_period", 16'h0001, 1'b0);
        step(1);
        check("second_tick", 16'h0002, 1'b0);

        // Table-driven vectors.
        for (int v = 0; v < 27; v++) begin
            habilita    = vecs[v].hab;
            direcao     = vecs[v].dir;
            carrega     = vecs[v].ld;
            valor_carga = vecs[v].val;
            step(vecs[v].ncyc);
            check($sformatf("vec%0d", v), vecs[v].exp_dig, vecs[v].exp_est);
        end

        // Reset mid-count at 0517, then a full period after release.
        habilita    = 1'b1;
        direcao     = 1'b1;
        carrega     = 1'b1;
        valor_carga = 16'h0517;
        step(1);
        carrega = 1'b0;
        step(2);
        check("pre_reset", 16'h0517, 1'b0);
        reset = 1'b1;
        step(1);
        check("reset_mid", 16'h0000, 1'b0);
        reset = 1'b0;
        step(3);
        check("post_reset_hold", 16'h0000, 1'b0);
        step(1);
        check("post_reset_tick", 16'h0001, 1'b0);

        // Reset has priority over a simultaneous load.
        reset       = 1'b1;
        carrega     = 1'b1;
        valor_carga = 16'h0777;
        step(1);
        check("reset_over_load", 16'h0000, 1'b0);
        reset   = 1'b0;
        carrega = 1'b0;
        step(1);
        check("after_reset_load", 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
